alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for the single shared combinational ALU.
//  Latches one granted op, drives the ALU from registers, and holds it for the op's latency.
//  Returns the registered result on one valid/ready response channel tagged with the requester id.
//  Sits between the pipeline EX stage (requester 0) and the aux/debug unit (requester 1) and the ALU instance.
// PARAMETERS
//  DATA_W   32  operand/result width
//  MUL_LAT  3   EXEC cycles for op 3'b101 (MUL); legal range 1..15; all other ops take 1 cycle
//  CNT_W    16  width of statistics counters (used only with ALU_ARB_STATS_EN)
// PORTS
//  clk_i         in   1       clock, rising edge
//  rst_i         in   1       synchronous, active-low reset
//  req0_valid_i  in   1       requester 0 has an op
//  req0_ready_o  out  1       requester 0 op accepted this cycle
//  req0_ctrl_i   in   3       ALU op code, requester 0
//  req0_a_i      in   DATA_W  operand 1, requester 0
//  req0_b_i      in   DATA_W  operand 2, requester 0
//  req1_*        same set for requester 1
//  alu_data1_o   out  DATA_W  registered operand 1 to ALU
//  alu_data2_o   out  DATA_W  registered operand 2 to ALU
//  alu_ctrl_o    out  3       registered op code to ALU
//  alu_result_i  in   DATA_W  ALU result (combinational from alu_*_o)
//  rsp_valid_o   out  1       result available
//  rsp_ready_i   in   1       consumer takes result
//  rsp_data_o    out  DATA_W  result
//  rsp_id_o      out  1       0/1: requester that issued the op
//  busy_o        out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_i==0 at an edge): state=IDLE, all *_ready_o/rsp_valid_o/busy_o=0; alu_*_o, rsp_data_o, rsp_id_o=0; last_grant=1.
//  Reset mid-operation aborts the op with no response; an in-flight result is discarded.
//  FSM: IDLE -> EXEC on accept; EXEC -> DONE when lat_cnt==lat-1; DONE -> IDLE on rsp_valid_o&&rsp_ready_i.
//  Arbitration (IDLE only, combinational): one valid requester -> it wins; both valid -> the one != last_grant wins.
//  reqN_ready_o=1 only in IDLE and only for the winner; never both. Accept = valid&&ready; last_grant<=N on accept.
//  On accept: alu_data1_o/alu_data2_o/alu_ctrl_o <= winner payload; rsp_id_o<=N; lat_cnt<=0.
//  Requesters hold valid and payload stable until ready; deasserting valid before ready is permitted.
//  EXEC: lat = MUL_LAT if alu_ctrl_o==3'b101 else 1; lat_cnt increments each cycle.
//  On the last EXEC cycle: rsp_data_o<=alu_result_i.
//  Latency: accept edge T -> rsp_valid_o high from T+lat (MUL_LAT=3: MUL at T+3, others at T+1).
//  DONE: rsp_valid_o=1; rsp_data_o/rsp_id_o stable until handshake; no new accept in DONE (no IDLE/DONE overlap).
//  Min issue interval = lat+1 cycles with rsp_ready_i tied high.
//  Op codes 3'b110/3'b111 pass through unchanged; they are SRA-by-default in the ALU and take 1 cycle.
//  Operands are not interpreted; width, sign and overflow rules belong to the ALU (result truncated to DATA_W).
//  rsp_ready_i held low: stay in DONE indefinitely and hold off both requesters.
//  busy_o = (state != IDLE).
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: adds stat_gnt0_o, stat_gnt1_o (out, CNT_W) and stat_stall_o (out, CNT_W).
//    stat_gntN_o counts accepts per requester.
//    stat_stall_o counts cycles where some reqN_valid_i=1 && reqN_ready_o=0.
//    All three saturate at all-ones and clear on reset.
//  ALU_ARB_STATS_EN undefined: these ports and their counters do not exist; all other behaviour is identical.
// STRUCTURE
//  alu_pkg: ALU op constants ALU_AND=3'b000, ALU_XOR=001, ALU_SLL=010, ALU_ADD=011, ALU_SUB=100,
//    ALU_MUL=101, ALU_SRA=110; FSM state encoding ST_IDLE/ST_EXEC/ST_DONE.
//  Sub-module rr_arb2: 2-way round-robin picker (valid[1:0], last_grant -> grant[1:0]), purely combinational.
//  The ALU itself is instantiated by the parent, not inside this block.
// TESTING
//  Single ADD: req0 ctrl=011 a=5 b=7 -> req0_ready_o=1 at T, rsp_valid_o at T+1, rsp_data=12, rsp_id=0.
//  MUL latency: req1 ctrl=101 a=-3 b=4, MUL_LAT=3 -> rsp_valid_o at T+3, rsp_data=32'hFFFFFFF4, rsp_id=1.
//  Contention: both valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; req0 wins first after reset.
//  Backpressure: rsp_ready_i=0 for 5 cycles in DONE -> rsp_* stable, both req ready=0, no accept; release -> IDLE next cycle.
//  Reset mid-EXEC: rst_i=0 during MUL EXEC -> next cycle all outputs 0, no rsp_valid_o; next op after reset runs normally.
//  Stats (ALU_ARB_STATS_EN): 3 accepts req0, 2 accepts req1 -> stat_gnt0=3, stat_gnt1=2;
//    stall counter matches the cycle count of waiting requesters.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: shared ALU op codes, FSM encoding and counter widths for the ALU share arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;

    // Latency counter width; covers MUL_LAT up to 15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin picker; the requester that did not win last time takes a tie.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own readiness.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester wins outright; on a tie the one other than last_grant wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Purpose: arbitrates two requesters onto one shared combinational ALU and returns tagged results.
// Latency: result valid lat cycles after the accept edge (MUL_LAT for MUL, 1 otherwise).
// Backpressure: rsp_ready_i low holds the result in DONE and keeps both requesters off; ALU_ARB_STATS_EN adds counters.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_ctrl_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_ctrl_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_id_o,
    output logic              busy_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_gnt0_o,
    output logic [CNT_W-1:0]  stat_gnt1_o,
    output logic [CNT_W-1:0]  stat_stall_o
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [LAT_W-1:0] lat_last;
    logic             last_grant_q;
    logic [1:0]       grant;
    logic [1:0]       accept;
    logic             last_exec;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid_i, req0_valid_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Offers are only made while idle, so DONE and a new accept never overlap.
    assign req0_ready_o = (state_q == ST_IDLE) && grant[0];
    assign req1_ready_o = (state_q == ST_IDLE) && grant[1];
    assign accept       = {req1_valid_i && req1_ready_o, req0_valid_i && req0_ready_o};

    // Only MUL is multi-cycle; the latched op code selects the hold time.
    assign lat_last    = (alu_ctrl_o == ALU_MUL) ? LAT_W'(MUL_LAT - 1) : '0;
    assign last_exec   = (state_q == ST_EXEC) && (lat_cnt_q == lat_last);
    assign rsp_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept -> hold for the op latency -> wait for the response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|accept)     state_d = ST_EXEC;
            ST_EXEC: if (last_exec)   state_d = ST_DONE;
            ST_DONE: if (rsp_ready_i) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Operand/result registers: latch the winner on accept, capture the ALU on the last EXEC cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lat_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_ctrl_o   <= '0;
            rsp_data_o   <= '0;
            rsp_id_o     <= 1'b0;
        end else if (|accept) begin
            alu_data1_o  <= accept[1] ? req1_a_i    : req0_a_i;
            alu_data2_o  <= accept[1] ? req1_b_i    : req0_b_i;
            alu_ctrl_o   <= accept[1] ? req1_ctrl_i : req0_ctrl_i;
            rsp_id_o     <= accept[1];
            last_grant_q <= accept[1];
            lat_cnt_q    <= '0;
        end else if (state_q == ST_EXEC) begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            if (last_exec) begin
                rsp_data_o <= alu_result_i;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic stall;
    assign stall = (req0_valid_i && !req0_ready_o) || (req1_valid_i && !req1_ready_o);

    // Saturating grant and stall counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_gnt0_o  <= '0;
            stat_gnt1_o  <= '0;
            stat_stall_o <= '0;
        end else begin
            if (accept[0] && (stat_gnt0_o != '1)) stat_gnt0_o  <= stat_gnt0_o + CNT_W'(1);
            if (accept[1] && (stat_gnt1_o != '1)) stat_gnt1_o  <= stat_gnt1_o + CNT_W'(1);
            if (stall && (stat_stall_o != '1))    stat_stall_o <= stat_stall_o + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Purpose: self-checking bench for alu_share_arb with a behavioural ALU and a timestamp-based reference model.
// Latency: model expects the result lat+1 sampled cycles after the cycle that shows ready.
// Backpressure: random rsp_ready; requesters hold payload until accepted. Stats checks under ALU_ARB_STATS_EN.
module tb_alu_share_arb;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic          r0, r1;
    logic [2:0]    c0 = '0, c1 = '0;
    logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [DW-1:0] alu_d1, alu_d2, alu_res, rsp_data;
    logic [2:0]    alu_ctrl;
    logic          rsp_valid, rsp_id, busy;
    logic          rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]   st_g0, st_g1, st_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The shared ALU as seen by the arbiter: result truncated to DW.
    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a ^ b;
            3'b010:  return a << b[4:0];
            3'b011:  return a + b;
            3'b100:  return a - b;
            3'b101:  return a * b;
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    assign alu_res = alu_f(alu_ctrl, alu_d1, alu_d2);

    alu_share_arb #(.DATA_W(DW), .MUL_LAT(LAT), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_ctrl_i  (c0),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_ctrl_i  (c1),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .alu_data1_o  (alu_d1),
        .alu_data2_o  (alu_d2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .busy_o       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_gnt0_o  (st_g0),
        .stat_gnt1_o  (st_g1),
        .stat_stall_o (st_stall)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({r0, r1, rsp_valid, busy} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl got=%b want=0000", {r0, r1, rsp_valid, busy});
        end
        n_vec++;
        if ({alu_d1, alu_d2, alu_ctrl} !== 67'd0) begin
            n_err++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_d1, alu_d2, alu_ctrl);
        end
        n_vec++;
        if ({rsp_data, rsp_id} !== 33'd0) begin
            n_err++; $display("FAIL reset_rsp got=%h/%b want=0", rsp_data, rsp_id);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        rsp_ready = 1'b1;
        v0 = 1'b1; c0 = 3'b011; a0 = 32'd5; b0 = 32'd7;
        @(negedge clk);
        n_vec++;
        if ({r0, r1} !== 2'b10) begin
            n_err++; $display("FAIL add_ready got=%b%b want=10", r0, r1);
        end
        step();
        v0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_valid, alu_ctrl, alu_d1, alu_d2} !== {1'b1, 1'b0, 3'b011, 32'd5, 32'd7}) begin
            n_err++; $display("FAIL add_exec got busy=%b vld=%b ctrl=%h d1=%h d2=%h want 1 0 3 5 7",
                              busy, rsp_valid, alu_ctrl, alu_d1, alu_d2);
        end
        step();
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 32'd12, 1'b0}) begin
            n_err++; $display("FAIL add_rsp got vld=%b data=%h id=%b want 1 0000000c 0", rsp_valid, rsp_data, rsp_id);
        end
        step();
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL add_idle got busy=%b vld=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_mul_latency();
        do_reset();
        rsp_ready = 1'b1;
        v1 = 1'b1; c1 = 3'b101; a1 = -32'sd3; b1 = 32'd4;
        @(negedge clk);
        n_vec++;
        if ({r0, r1} !== 2'b01) begin
            n_err++; $display("FAIL mul_ready got=%b%b want=01", r0, r1);
        end
        step();
        v1 = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== (k == LAT + 1)) begin
                n_err++; $display("FAIL mul_lat cycle=%0d got vld=%b want=%b", k, rsp_valid, (k == LAT + 1));
            end
            if (k == LAT + 1) begin
                n_vec++;
                if ({rsp_data, rsp_id} !== {32'hFFFFFFF4, 1'b1}) begin
                    n_err++; $display("FAIL mul_rsp got data=%h id=%b want fffffff4 1", rsp_data, rsp_id);
                end
            end
            step();
        end
    endtask

    task automatic test_contention();
        int gid[$];
        do_reset();
        rsp_ready = 1'b1;
        v0 = 1'b1; c0 = 3'b011; a0 = 32'd1; b0 = 32'd1;
        v1 = 1'b1; c1 = 3'b001; a1 = 32'd3; b1 = 32'd5;
        for (int k = 0; k < 60 && gid.size() < 6; k++) begin
            @(negedge clk);
            n_vec++;
            if (r0 && r1) begin
                n_err++; $display("FAIL cont_both cycle=%0d got r0=1 r1=1 want at most one", k);
            end
            if (r0 || r1) gid.push_back(int'(r1));
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        n_vec++;
        if (gid.size() != 6) begin
            n_err++; $display("FAIL cont_count got=%0d want=6", gid.size());
        end
        for (int i = 0; i < gid.size(); i++) begin
            n_vec++;
            if (gid[i] != i % 2) begin
                n_err++; $display("FAIL cont_order grant%0d got=%0d want=%0d", i, gid[i], i % 2);
            end
        end
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        do_reset();
        v0 = 1'b1; c0 = 3'b001; a0 = 32'h0000F0F0; b0 = 32'h00000FF0;
        @(negedge clk);
        step();
        v1 = 1'b1; c1 = 3'b011; a1 = 32'd2; b1 = 32'd2;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_data, rsp_id, r0, r1, busy} !== {1'b1, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_err++; $display("FAIL bp_hold cycle=%0d got vld=%b data=%h id=%b r=%b%b busy=%b want 1 0000ff00 0 00 1",
                                  k, rsp_valid, rsp_data, rsp_id, r0, r1, busy);
            end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000FF00}) begin
            n_err++; $display("FAIL bp_release got vld=%b data=%h want 1 0000ff00", rsp_valid, rsp_data);
        end
        step();
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_valid, r0, r1} !== 4'b0001) begin
            n_err++; $display("FAIL bp_idle got busy=%b vld=%b r=%b%b want 0 0 01", busy, rsp_valid, r0, r1);
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        rsp_ready = 1'b1;
        v0 = 1'b1; c0 = 3'b101; a0 = 32'd7; b0 = 32'd9;
        @(negedge clk);
        step();
        v0 = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, busy, alu_d1, alu_d2, alu_ctrl, rsp_data, rsp_id} !== 101'd0) begin
            n_err++; $display("FAIL rst_exec got vld=%b busy=%b d1=%h d2=%h ctrl=%h data=%h id=%b want all 0",
                              rsp_valid, busy, alu_d1, alu_d2, alu_ctrl, rsp_data, rsp_id);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_norsp cycle=%0d got vld=%b want 0", k, rsp_valid);
            end
        end
        step();
        v1 = 1'b1; c1 = 3'b011; a1 = 32'd1; b1 = 32'd2;
        @(negedge clk);
        n_vec++;
        if ({r0, r1} !== 2'b01) begin
            n_err++; $display("FAIL rst_next_ready got=%b%b want=01", r0, r1);
        end
        step();
        v1 = 1'b0;
        step();
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 32'd3, 1'b1}) begin
            n_err++; $display("FAIL rst_next_rsp got vld=%b data=%h id=%b want 1 00000003 1", rsp_valid, rsp_data, rsp_id);
        end
        step();
    endtask

    // Reference model: one op outstanding at a time, result due lat+1 cycles after the ready cycle.
    task automatic test_random();
        bit            outst = 1'b0;
        int            due = 0;
        logic [DW-1:0] exp_d = '0;
        logic          exp_id = 1'b0;
        logic [2:0]    exp_c = '0;
        logic          last_m = 1'b1;
        bit            hold0 = 1'b0, hold1 = 1'b0;
        logic          w0, w1, exp_rv;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (!hold0) begin
                v0 = 1'($urandom_range(0, 1)); c0 = 3'($urandom_range(0, 7)); a0 = $urandom; b0 = $urandom;
            end
            if (!hold1) begin
                v1 = 1'($urandom_range(0, 1)); c1 = 3'($urandom_range(0, 7)); a1 = $urandom; b1 = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rv = outst && (c >= due);
            n_vec++;
            if (rsp_valid !== exp_rv) begin
                n_err++; $display("FAIL rnd_valid cycle=%0d got=%b want=%b", c, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                n_vec++;
                if ({rsp_data, rsp_id} !== {exp_d, exp_id}) begin
                    n_err++; $display("FAIL rnd_rsp cycle=%0d got data=%h id=%b want data=%h id=%b",
                                      c, rsp_data, rsp_id, exp_d, exp_id);
                end
            end
            n_vec++;
            if (busy !== outst) begin
                n_err++; $display("FAIL rnd_busy cycle=%0d got=%b want=%b", c, busy, outst);
            end
            if (outst) begin
                n_vec++;
                if (alu_ctrl !== exp_c) begin
                    n_err++; $display("FAIL rnd_ctrl cycle=%0d got=%h want=%h", c, alu_ctrl, exp_c);
                end
            end
            w0 = !outst && v0 && (!v1 || last_m);
            w1 = !outst && v1 && (!v0 || !last_m);
            n_vec++;
            if ({r0, r1} !== {w0, w1}) begin
                n_err++; $display("FAIL rnd_ready cycle=%0d got=%b%b want=%b%b", c, r0, r1, w0, w1);
            end
            @(posedge clk);
            if (exp_rv && rsp_ready) outst = 1'b0;
            if (w0 || w1) begin
                outst  = 1'b1;
                last_m = w1;
                exp_id = w1;
                exp_c  = w1 ? c1 : c0;
                exp_d  = w1 ? alu_f(c1, a1, b1) : alu_f(c0, a0, b0);
                due    = c + 1 + ((exp_c == 3'b101) ? LAT : 1);
            end
            hold0 = v0 && !w0;
            hold1 = v1 && !w1;
            #1;
        end
        v0 = 1'b0; v1 = 1'b0;
        rsp_ready = 1'b1;
        repeat (LAT + 3) step();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        int   rem0 = 3, rem1 = 2, stall_exp = 0, due = 0;
        bit   outst = 1'b0;
        logic last_m = 1'b1;
        logic w0, w1;
        do_reset();
        rsp_ready = 1'b1;
        c0 = 3'b011; a0 = 32'd1; b0 = 32'd2;
        c1 = 3'b000; a1 = 32'd3; b1 = 32'd6;
        for (int c = 0; c < 80 && (rem0 > 0 || rem1 > 0 || outst); c++) begin
            v0 = (rem0 > 0);
            v1 = (rem1 > 0);
            @(negedge clk);
            w0 = !outst && v0 && (!v1 || last_m);
            w1 = !outst && v1 && (!v0 || !last_m);
            if ((v0 && !w0) || (v1 && !w1)) stall_exp++;
            @(posedge clk);
            if (outst && c >= due) outst = 1'b0;
            if (w0 || w1) begin
                outst  = 1'b1;
                last_m = w1;
                due    = c + 2;
                if (w0) rem0--; else rem1--;
            end
            #1;
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (st_g0 !== 16'd3) begin
            n_err++; $display("FAIL stat_gnt0 got=%0d want=3", st_g0);
        end
        n_vec++;
        if (st_g1 !== 16'd2) begin
            n_err++; $display("FAIL stat_gnt1 got=%0d want=2", st_g1);
        end
        n_vec++;
        if (st_stall !== 16'(stall_exp)) begin
            n_err++; $display("FAIL stat_stall got=%0d want=%0d", st_stall, stall_exp);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_mul_latency();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
